mem_arbiter: RTL and testbench

- Shares one single-port, fixed-latency backing memory between the IF-stage fetch port and the MEM-stage load/store port.
- Lets the core move from ideal combinational text/data memories to a unified memory.
- Sequences each access with an FSM and latency counter, gives data accesses priority, and returns per-port ready pulses.
- The top level turns the missing ready pulses into pipeline stalls.

---
 rtl/mem_arbiter_pkg.sv | 32 +++
 rtl/mem_arbiter_lat_counter.sv | 44 ++++
 rtl/mem_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//
// Purpose:
//   Shared definitions for the fetch/data memory arbiter:
//   - arbiter state encoding (idle, data access busy, fetch busy)
//   - the word-size MemLen code used for instruction fetches
//   - a saturating 32-bit increment helper for the stall statistics counter
//
// Ports:
//   none (package)
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DBUSY = 2'd1,
        ST_IBUSY = 2'd2
    } arb_state_e;

    // Fetches are always full instruction words.
    localparam logic [2:0] MEM_LEN_WORD = 3'b010;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            return value;
        end
        return value + 32'd1;
    endfunction

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_lat_counter.sv
// -----------------------------------------------------------------------------
// mem_arbiter_lat_counter
//
// Purpose:
//   Loadable down-counter that tracks the remaining cycles of the current
//   memory access. Loading has priority over decrementing; the count stops
//   at zero.
//
// Ports:
//   clk       in   clock
//   rst       in   asynchronous, active-low reset (count cleared to 0)
//   load      in   load load_val on the next rising edge
//   load_val  in   CNT_W  value to load
//   dec       in   decrement by one (ignored when the count is already 0)
//   zero      out  count is zero
// -----------------------------------------------------------------------------
module mem_arbiter_lat_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // A load starts a fresh access. Otherwise the counter counts down while
    // an access is busy and then waits at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule : mem_arbiter_lat_counter

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares a single-port, fixed-latency backing memory between the IF-stage
//   fetch port and the MEM-stage load/store port. Each access takes LATENCY
//   busy cycles. Read data from the memory is valid in the last busy cycle.
//   Data accesses win over fetches. A fetch already in flight is not
//   preempted, but a branch redirect (if_flush) can drop it. Each port gets a
//   one-cycle ready pulse when its access completes. The pipeline turns a
//   missing ready into a stall.
//
// Ports:
//   clk           in   clock
//   rst           in   asynchronous, active-low reset
//   if_req        in   fetch request, held until if_ready or if_flush
//   if_addr       in   WIDTH  fetch address
//   if_flush      in   drop pending / in-flight fetch
//   if_ready      out  one-cycle pulse, fetch done
//   if_rdata      out  WIDTH  fetched instruction (held after if_ready)
//   d_req         in   data request, held until d_ready
//   d_we          in   1 = store
//   d_len         in   3  access size code, forwarded unchanged
//   d_addr        in   WIDTH  data address
//   d_wdata       in   WIDTH  store data
//   d_ready       out  one-cycle pulse, data access done
//   d_rdata       out  WIDTH  load data (0 for stores, held after d_ready)
//   m_en          out  memory enable
//   m_we          out  memory write enable
//   m_len         out  3  size code to memory
//   m_addr        out  WIDTH  memory address
//   m_wdata       out  WIDTH  memory write data
//   m_rdata       in   WIDTH  memory read data
//   stall_cycles  out  32  saturating count of cycles with an unserved request
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter int CNT_W   = $clog2(LATENCY) + 1
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    input  logic             if_flush,
    output logic             if_ready,
    output logic [WIDTH-1:0] if_rdata,

    input  logic             d_req,
    input  logic             d_we,
    input  logic [2:0]       d_len,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic             d_ready,
    output logic [WIDTH-1:0] d_rdata,

    output logic             m_en,
    output logic             m_we,
    output logic [2:0]       m_len,
    output logic [WIDTH-1:0] m_addr,
    output logic [WIDTH-1:0] m_wdata,
    input  logic [WIDTH-1:0] m_rdata,

    output logic [31:0]      stall_cycles
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    arb_state_e       state;
    logic             cnt_zero;
    logic             grant_d;
    logic             grant_i;
    logic             cnt_load;
    logic             cnt_dec;

    // Command captured at grant time. The requesting stage only has to hold
    // its request stable, so the arbiter keeps its own copy for the whole
    // access.
    logic             cmd_we;
    logic [2:0]       cmd_len;
    logic [WIDTH-1:0] cmd_addr;
    logic [WIDTH-1:0] cmd_wdata;

    logic [WIDTH-1:0] if_rdata_q;
    logic [WIDTH-1:0] d_rdata_q;
    logic [WIDTH-1:0] d_rdata_next;
    logic [31:0]      stall_q;
    logic             stall_now;

    // Grant decision in IDLE: data first. A fetch is only taken when it is
    // not being flushed in the same cycle.
    assign grant_d  = (state == ST_IDLE) && d_req;
    assign grant_i  = (state == ST_IDLE) && !d_req && if_req && !if_flush;
    assign cnt_load = grant_d || grant_i;
    assign cnt_dec  = (state != ST_IDLE);

    mem_arbiter_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (LOAD_VAL),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Ready pulses depend only on state, counter and flush, never on the
    // request lines. The stall logic feeds back into the requests, so this
    // keeps the loop open.
    assign d_ready  = (state == ST_DBUSY) && cnt_zero;
    assign if_ready = (state == ST_IBUSY) && cnt_zero && !if_flush;

    // Stores return zero so a stale load value never leaks into the pipeline.
    assign d_rdata_next = cmd_we ? '0 : m_rdata;

    // Read data passes through in the ready cycle and is held afterwards.
    assign d_rdata  = d_ready  ? d_rdata_next : d_rdata_q;
    assign if_rdata = if_ready ? m_rdata      : if_rdata_q;

    // Memory command. Everything is quiet in IDLE. Fetches are word reads.
    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_len   = 3'b000;
        m_addr  = '0;
        m_wdata = '0;
        case (state)
            ST_DBUSY: begin
                m_en    = 1'b1;
                m_we    = cmd_we;
                m_len   = cmd_len;
                m_addr  = cmd_addr;
                m_wdata = cmd_wdata;
            end
            ST_IBUSY: begin
                m_en    = 1'b1;
                m_len   = MEM_LEN_WORD;
                m_addr  = cmd_addr;
            end
            default: begin
            end
        endcase
    end

    // Arbiter FSM. It captures the granted command and registers read data
    // in the ready cycle. A flush in IBUSY drops the fetch without a ready
    // pulse. Data accesses always run to completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cmd_we     <= 1'b0;
            cmd_len    <= 3'b000;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_d) begin
                        cmd_we    <= d_we;
                        cmd_len   <= d_len;
                        cmd_addr  <= d_addr;
                        cmd_wdata <= d_wdata;
                        state     <= ST_DBUSY;
                    end else if (grant_i) begin
                        cmd_we    <= 1'b0;
                        cmd_len   <= MEM_LEN_WORD;
                        cmd_addr  <= if_addr;
                        cmd_wdata <= '0;
                        state     <= ST_IBUSY;
                    end
                end
                ST_DBUSY: begin
                    if (cnt_zero) begin
                        d_rdata_q <= d_rdata_next;
                        state     <= ST_IDLE;
                    end
                end
                ST_IBUSY: begin
                    if (if_flush) begin
                        state <= ST_IDLE;
                    end else if (cnt_zero) begin
                        if_rdata_q <= m_rdata;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // A cycle counts as a stall when either port has a live request that is
    // not being answered this cycle. The counter counts each cycle once, even
    // when both ports wait.
    assign stall_now = (d_req && !d_ready) || (if_req && !if_ready && !if_flush);

    // Saturating stall statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= 32'd0;
        end else if (stall_now) begin
            stall_q <= sat_inc32(stall_q);
        end
    end

    assign stall_cycles = stall_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Purpose:
//   Directed self-checking bench for mem_arbiter with LATENCY=2. Inputs are
//   driven 1 time unit after the rising edge. Outputs are sampled on the
//   falling edge. "Cycle N" is the cycle in which a request is first driven.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int WIDTH   = 32;
    localparam int LATENCY = 2;

    logic             clk;
    logic             rst;
    logic             if_req;
    logic [WIDTH-1:0] if_addr;
    logic             if_flush;
    logic             if_ready;
    logic [WIDTH-1:0] if_rdata;
    logic             d_req;
    logic             d_we;
    logic [2:0]       d_len;
    logic [WIDTH-1:0] d_addr;
    logic [WIDTH-1:0] d_wdata;
    logic             d_ready;
    logic [WIDTH-1:0] d_rdata;
    logic             m_en;
    logic             m_we;
    logic [2:0]       m_len;
    logic [WIDTH-1:0] m_addr;
    logic [WIDTH-1:0] m_wdata;
    logic [WIDTH-1:0] m_rdata;
    logic [31:0]      stall_cycles;

    int check_count = 0;
    int pass_count  = 0;

    mem_arbiter #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_flush     (if_flush),
        .if_ready     (if_ready),
        .if_rdata     (if_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_len        (d_len),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_ready      (d_ready),
        .d_rdata      (d_rdata),
        .m_en         (m_en),
        .m_we         (m_we),
        .m_len        (m_len),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_rdata      (m_rdata),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Go to the falling edge of the current cycle, where outputs are sampled.
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        if_req   = 1'b0;
        if_addr  = '0;
        if_flush = 1'b0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_len    = 3'b000;
        d_addr   = '0;
        d_wdata  = '0;
        m_rdata  = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        sample();
        check_count++; if (m_en !== 1'b0) $display("[TB] FAIL reset_m_en: got %0h expected 0", m_en); else pass_count++;
        check_count++; if (stall_cycles !== 32'd0) $display("[TB] FAIL reset_stall: got %0d expected 0", stall_cycles); else pass_count++;
        check_count++; if (d_rdata !== 32'd0 || if_rdata !== 32'd0) $display("[TB] FAIL reset_rdata: got %h/%h expected 0/0", d_rdata, if_rdata); else pass_count++;
        // Load at N, then assert reset in the middle of DBUSY (N+1).
        tick();
        d_req = 1'b1; d_we = 1'b0; d_len = 3'b010; d_addr = 32'h0000_0080; m_rdata = 32'h1111_2222;
        tick();
        sample();
        check_count++; if (m_en !== 1'b1) $display("[TB] FAIL reset_pre_busy: got %0h expected 1", m_en); else pass_count++;
        #1;
        rst = 1'b0;
        d_req = 1'b0;
        #1;
        check_count++; if (m_en !== 1'b0 || d_ready !== 1'b0) $display("[TB] FAIL reset_async: got m_en=%0h d_ready=%0h expected 0/0", m_en, d_ready); else pass_count++;
        check_count++; if (stall_cycles !== 32'd0) $display("[TB] FAIL reset_async_stall: got %0d expected 0", stall_cycles); else pass_count++;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            check_count++; if (d_ready !== 1'b0 || m_en !== 1'b0) $display("[TB] FAIL reset_no_pulse: cycle %0d got d_ready=%0h m_en=%0h expected 0/0", i, d_ready, m_en); else pass_count++;
            tick();
        end
    endtask

    task automatic test_fetch();
        apply_reset();
        tick();
        if_req = 1'b1; if_addr = 32'h10; m_rdata = 32'h0050_0093;
        sample();
        check_count++; if (m_en !== 1'b0) $display("[TB] FAIL fetch_n_idle: got %0h expected 0", m_en); else pass_count++;
        tick();
        sample();
        check_count++; if (m_en !== 1'b1 || m_addr !== 32'h10 || m_we !== 1'b0) $display("[TB] FAIL fetch_n1_cmd: got en=%0h addr=%h we=%0h expected 1/00000010/0", m_en, m_addr, m_we); else pass_count++;
        check_count++; if (if_ready !== 1'b0) $display("[TB] FAIL fetch_n1_ready: got %0h expected 0", if_ready); else pass_count++;
        tick();
        sample();
        check_count++; if (m_en !== 1'b1 || m_addr !== 32'h10 || m_len !== 3'b010) $display("[TB] FAIL fetch_n2_cmd: got en=%0h addr=%h len=%0h expected 1/00000010/2", m_en, m_addr, m_len); else pass_count++;
        check_count++; if (if_ready !== 1'b1 || if_rdata !== 32'h0050_0093) $display("[TB] FAIL fetch_n2_ready: got %0h/%h expected 1/00500093", if_ready, if_rdata); else pass_count++;
        tick();
        if_req = 1'b0; m_rdata = 32'hFFFF_0000;
        tick();
        tick();
        sample();
        check_count++; if (if_rdata !== 32'h0050_0093 || if_ready !== 1'b0) $display("[TB] FAIL fetch_n5_hold: got %h/%0h expected 00500093/0", if_rdata, if_ready); else pass_count++;
    endtask

    task automatic test_collision();
        apply_reset();
        tick();
        if_req = 1'b1; if_addr = 32'h30;
        d_req = 1'b1; d_we = 1'b0; d_len = 3'b010; d_addr = 32'h20; m_rdata = 32'h55;
        tick();
        sample();
        check_count++; if (m_addr !== 32'h20 || m_we !== 1'b0) $display("[TB] FAIL coll_n1_data_first: got addr=%h we=%0h expected 00000020/0", m_addr, m_we); else pass_count++;
        tick();
        sample();
        check_count++; if (d_ready !== 1'b1 || d_rdata !== 32'h55 || if_ready !== 1'b0) $display("[TB] FAIL coll_n2_dready: got %0h/%h/%0h expected 1/00000055/0", d_ready, d_rdata, if_ready); else pass_count++;
        tick();
        d_req = 1'b0;
        sample();
        check_count++; if (m_en !== 1'b0) $display("[TB] FAIL coll_n3_idle: got %0h expected 0", m_en); else pass_count++;
        tick();
        sample();
        check_count++; if (m_en !== 1'b1 || m_addr !== 32'h30) $display("[TB] FAIL coll_n4_fetch: got %0h/%h expected 1/00000030", m_en, m_addr); else pass_count++;
        tick();
        sample();
        check_count++; if (if_ready !== 1'b1 || if_rdata !== 32'h55) $display("[TB] FAIL coll_n5_iready: got %0h/%h expected 1/00000055", if_ready, if_rdata); else pass_count++;
        check_count++; if (d_rdata !== 32'h55) $display("[TB] FAIL coll_n5_dhold: got %h expected 00000055", d_rdata); else pass_count++;
        tick();
        if_req = 1'b0;
        sample();
        check_count++; if (stall_cycles !== 32'd5) $display("[TB] FAIL coll_stall: got %0d expected 5", stall_cycles); else pass_count++;
    endtask

    task automatic test_store();
        apply_reset();
        tick();
        d_req = 1'b1; d_we = 1'b1; d_len = 3'b010; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; m_rdata = 32'h1234_5678;
        tick();
        sample();
        check_count++; if (m_we !== 1'b1 || m_wdata !== 32'hDEAD_BEEF || m_addr !== 32'h40 || m_len !== 3'b010) $display("[TB] FAIL store_n1_cmd: got we=%0h wdata=%h addr=%h len=%0h expected 1/deadbeef/00000040/2", m_we, m_wdata, m_addr, m_len); else pass_count++;
        tick();
        sample();
        check_count++; if (m_we !== 1'b1 || m_wdata !== 32'hDEAD_BEEF) $display("[TB] FAIL store_n2_cmd: got %0h/%h expected 1/deadbeef", m_we, m_wdata); else pass_count++;
        check_count++; if (d_ready !== 1'b1 || d_rdata !== 32'd0) $display("[TB] FAIL store_n2_ready: got %0h/%h expected 1/00000000", d_ready, d_rdata); else pass_count++;
        tick();
        d_req = 1'b0; d_we = 1'b0;
        sample();
        check_count++; if (d_ready !== 1'b0 || m_en !== 1'b0 || m_we !== 1'b0) $display("[TB] FAIL store_n3_idle: got %0h/%0h/%0h expected 0/0/0", d_ready, m_en, m_we); else pass_count++;
    endtask

    task automatic test_flush();
        int pulses;
        apply_reset();
        // Flush in IDLE blocks the grant.
        tick();
        if_req = 1'b1; if_addr = 32'h50; if_flush = 1'b1;
        tick();
        if_req = 1'b0; if_flush = 1'b0;
        sample();
        check_count++; if (m_en !== 1'b0) $display("[TB] FAIL flush_idle_ignored: got %0h expected 0", m_en); else pass_count++;
        // Flush of an in-flight fetch.
        tick();
        if_req = 1'b1; if_addr = 32'h50; m_rdata = 32'hCAFE_0001;
        pulses = 0;
        tick();
        if_flush = 1'b1;
        sample();
        if (if_ready === 1'b1) pulses++;
        check_count++; if (m_en !== 1'b1) $display("[TB] FAIL flush_n1_busy: got %0h expected 1", m_en); else pass_count++;
        tick();
        if_flush = 1'b0; if_req = 1'b0;
        sample();
        if (if_ready === 1'b1) pulses++;
        check_count++; if (m_en !== 1'b0) $display("[TB] FAIL flush_n2_idle: got %0h expected 0", m_en); else pass_count++;
        for (int i = 0; i < 3; i++) begin
            tick();
            sample();
            if (if_ready === 1'b1) pulses++;
        end
        check_count++; if (pulses !== 0) $display("[TB] FAIL flush_no_ready: got %0d pulses expected 0", pulses); else pass_count++;
        check_count++; if (if_rdata !== 32'd0) $display("[TB] FAIL flush_rdata: got %h expected 00000000", if_rdata); else pass_count++;
    endtask

    task automatic test_data_during_fetch();
        apply_reset();
        tick();
        if_req = 1'b1; if_addr = 32'h60; m_rdata = 32'hAA;
        tick();
        d_req = 1'b1; d_we = 1'b0; d_len = 3'b001; d_addr = 32'h70;
        sample();
        check_count++; if (m_addr !== 32'h60 || d_ready !== 1'b0) $display("[TB] FAIL dfetch_n1_no_preempt: got %h/%0h expected 00000060/0", m_addr, d_ready); else pass_count++;
        tick();
        sample();
        check_count++; if (if_ready !== 1'b1 || if_rdata !== 32'hAA) $display("[TB] FAIL dfetch_n2_iready: got %0h/%h expected 1/000000aa", if_ready, if_rdata); else pass_count++;
        tick();
        if_req = 1'b0;
        sample();
        check_count++; if (m_en !== 1'b0) $display("[TB] FAIL dfetch_n3_idle: got %0h expected 0", m_en); else pass_count++;
        tick();
        sample();
        check_count++; if (m_en !== 1'b1 || m_addr !== 32'h70 || m_len !== 3'b001 || d_ready !== 1'b0) $display("[TB] FAIL dfetch_n4_dbusy: got %0h/%h/%0h/%0h expected 1/00000070/1/0", m_en, m_addr, m_len, d_ready); else pass_count++;
        tick();
        m_rdata = 32'hBB;
        sample();
        check_count++; if (d_ready !== 1'b1 || d_rdata !== 32'hBB) $display("[TB] FAIL dfetch_n5_dready: got %0h/%h expected 1/000000bb", d_ready, d_rdata); else pass_count++;
        tick();
        d_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        // A data request left high after d_ready starts a second access.
        tick();
        d_req = 1'b1; d_we = 1'b0; d_len = 3'b010; d_addr = 32'h90; m_rdata = 32'h77;
        tick();
        tick();
        sample();
        check_count++; if (d_ready !== 1'b1) $display("[TB] FAIL b2b_first_ready: got %0h expected 1", d_ready); else pass_count++;
        tick();
        sample();
        check_count++; if (m_en !== 1'b0 || d_ready !== 1'b0) $display("[TB] FAIL b2b_gap_idle: got %0h/%0h expected 0/0", m_en, d_ready); else pass_count++;
        tick();
        sample();
        check_count++; if (m_en !== 1'b1 || d_ready !== 1'b0) $display("[TB] FAIL b2b_second_busy: got %0h/%0h expected 1/0", m_en, d_ready); else pass_count++;
        tick();
        m_rdata = 32'h88;
        sample();
        check_count++; if (d_ready !== 1'b1 || d_rdata !== 32'h88) $display("[TB] FAIL b2b_second_ready: got %0h/%h expected 1/00000088", d_ready, d_rdata); else pass_count++;
        tick();
        d_req = 1'b0;
        tick();
        sample();
        check_count++; if (m_en !== 1'b0) $display("[TB] FAIL b2b_released: got %0h expected 0", m_en); else pass_count++;
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_fetch();
        test_collision();
        test_store();
        test_flush();
        test_data_during_fetch();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule : tb_mem_arbiter
